// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data memory-port arbiter with a fixed-latency access FSM.
// Round-robin arbitration between simultaneous requests is enabled by defining MEM_ARBITER_RR_EN.
module mem_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wren,
  input  logic [1:0]        d_width,
  input  logic              d_sign,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [1:0]        mem_width,
  output logic              mem_sign,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              grant_d
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       pick_d;
  logic       any_req;

  assign any_req = if_req | d_req;

`ifdef MEM_ARBITER_RR_EN
  // last_owner: 1 = data port was granted last; reset favours fetch on the first tie.
  logic last_owner;

  assign pick_d = d_req & (~if_req | ~last_owner);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_owner <= 1'b1;
    else if (state == IDLE && any_req)
      last_owner <= pick_d;
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      grant_d   <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
      mem_addr  <= '0;
      mem_wren  <= 1'b0;
      mem_width <= 2'b00;
      mem_sign  <= 1'b0;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= ACCESS;
            busy    <= 1'b1;
            grant_d <= pick_d;
            cnt     <= CNT_INIT;
            if (pick_d) begin
              mem_addr  <= d_addr;
              mem_wren  <= d_wren;
              mem_width <= d_width;
              mem_sign  <= d_sign;
              mem_wdata <= d_wdata;
            end else begin
              mem_addr  <= if_addr;
              mem_wren  <= 1'b0;
              mem_width <= 2'b10;
              mem_sign  <= 1'b0;
              mem_wdata <= 32'd0;
            end
          end
        end
        ACCESS: begin
          // The write strobe covers only the first access cycle of a store.
          mem_wren <= 1'b0;
          if (cnt == 4'd0) begin
            state <= DONE;
            if (grant_d) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (WAIT_CYCLES=2).
module tb_mem_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_wren, d_sign;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [1:0]    d_width, mem_width;
  logic [31:0]   d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          if_ack, d_ack, mem_wren, mem_sign, busy, grant_d;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wren(d_wren), .d_width(d_width),
    .d_sign(d_sign), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_width(mem_width),
    .mem_sign(mem_sign), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_d(grant_d)
  );

  function automatic logic [31:0] fn(input logic [AW-1:0] a);
    return (a == 10'h004) ? 32'h00500093 : (32'hC0DE0000 | {22'd0, a});
  endfunction

  assign mem_rdata = mem[mem_addr];

  // Scoreboard: every ack pops the oldest expected transfer.
  exp_t e;
  always @(negedge clk) begin
    if (rst === 1'b1 && (if_ack === 1'b1 || d_ack === 1'b1)) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ack if_ack=%0b d_ack=%0b", if_ack, d_ack);
      end else begin
        e = sbq.pop_front();
        if (d_ack !== e.is_d || if_ack !== ~e.is_d ||
            (e.is_d ? d_rdata : if_rdata) !== e.rdata) begin
          bad++;
          $display("FAIL sb_ack got if_ack=%0b d_ack=%0b rdata=%h want is_d=%0b rdata=%h",
                   if_ack, d_ack, e.is_d ? d_rdata : if_rdata, e.is_d, e.rdata);
        end
      end
    end
  end

  task test_reset;
    rst = 1'b0;
    if_req = 0; d_req = 0; d_wren = 0; d_sign = 0;
    if_addr = '0; d_addr = '0; d_width = 2'b00; d_wdata = 32'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, grant_d, if_ack, d_ack, mem_wren, mem_sign} !== 6'd0 ||
        mem_addr !== '0 || mem_width !== 2'b00 || mem_wdata !== 32'd0 ||
        if_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs busy=%0b grant_d=%0b acks=%0b%0b wren=%0b addr=%h rdata=%h/%h want all 0",
               busy, grant_d, if_ack, d_ack, mem_wren, mem_addr, if_rdata, d_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%0b want 0", busy);
    end
  endtask

  task test_fetch;
    if_addr = 10'h004;
    if_req  = 1'b1;
    sbq.push_back('{1'b0, 32'h00500093});
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if (c < 3) begin
        if (mem_addr !== 10'h004 || busy !== 1'b1 || grant_d !== 1'b0 ||
            mem_wren !== 1'b0 || mem_width !== 2'b10 || mem_sign !== 1'b0 || if_ack !== 1'b0) begin
          bad++;
          $display("FAIL fetch_access cyc=%0d addr=%h busy=%0b grant_d=%0b wren=%0b width=%0b ack=%0b want 004 1 0 0 10 0",
                   c, mem_addr, busy, grant_d, mem_wren, mem_width, if_ack);
        end
      end else begin
        if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== 32'h00500093) begin
          bad++;
          $display("FAIL fetch_ack if_ack=%0b d_ack=%0b rdata=%h want 1 0 00500093", if_ack, d_ack, if_rdata);
        end
        if_req = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (if_ack !== 1'b0 || busy !== 1'b0 || if_rdata !== 32'h00500093) begin
      bad++;
      $display("FAIL fetch_after ack=%0b busy=%0b rdata=%h want 0 0 00500093", if_ack, busy, if_rdata);
    end
  endtask

  task test_store;
    int wren_cnt, ack_cnt;
    wren_cnt = 0; ack_cnt = 0;
    d_addr = 10'h100; d_wren = 1'b1; d_width = 2'b00; d_sign = 1'b0; d_wdata = 32'h000000AB;
    d_req = 1'b1;
    sbq.push_back('{1'b1, fn(10'h100)});
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_wren === 1'b1) begin
        wren_cnt++;
        total++;
        if (c != 1 || mem_addr !== 10'h100 || mem_wdata !== 32'h000000AB || grant_d !== 1'b1) begin
          bad++;
          $display("FAIL store_wren cyc=%0d addr=%h wdata=%h grant_d=%0b want cyc 1 100 000000ab 1",
                   c, mem_addr, mem_wdata, grant_d);
        end
      end
      if (d_ack === 1'b1) begin
        ack_cnt++;
        d_req = 1'b0;
      end
    end
    d_wren = 1'b0;
    total++;
    if (wren_cnt != 1 || ack_cnt != 1) begin
      bad++;
      $display("FAIL store_pulses wren_cycles=%0d acks=%0d want 1 1", wren_cnt, ack_cnt);
    end
    total++;
    if (if_rdata !== 32'h00500093 || if_ack !== 1'b0) begin
      bad++;
      $display("FAIL store_nonowner if_rdata=%h if_ack=%0b want 00500093 0", if_rdata, if_ack);
    end
  endtask

  task test_arbitration;
    int n, cyc;
    logic chk_idle;
    n = 0; cyc = 0; chk_idle = 0;
    if_addr = 10'h010; d_addr = 10'h020; d_wren = 1'b0; d_width = 2'b10; d_sign = 1'b0;
`ifdef MEM_ARBITER_RR_EN
    sbq.push_back('{1'b0, fn(10'h010)});
    sbq.push_back('{1'b1, fn(10'h020)});
    sbq.push_back('{1'b0, fn(10'h010)});
    sbq.push_back('{1'b1, fn(10'h020)});
`else
    sbq.push_back('{1'b1, fn(10'h020)});
    sbq.push_back('{1'b1, fn(10'h020)});
    sbq.push_back('{1'b1, fn(10'h020)});
    sbq.push_back('{1'b0, fn(10'h010)});
`endif
    if_req = 1'b1;
    d_req  = 1'b1;
    while (n < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (chk_idle) begin
        chk_idle = 1'b0;
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL arb_idle_gap busy=%0b want 0", busy);
        end
      end
      if (if_ack === 1'b1 || d_ack === 1'b1) begin
        n++;
        chk_idle = 1'b1;
`ifdef MEM_ARBITER_RR_EN
        if (n == 4) begin
          if_req = 1'b0;
          d_req  = 1'b0;
        end
`else
        if (d_ack === 1'b1 && n == 3) d_req = 1'b0;
        if (if_ack === 1'b1) if_req = 1'b0;
`endif
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL arb_timeout acks=%0d want 4", n);
    end
    @(negedge clk);
  endtask

  task test_reset_mid;
    int ack_cnt;
    ack_cnt = 0;
    d_addr = 10'h040; d_wren = 1'b1; d_width = 2'b01; d_wdata = 32'h00000055;
    d_req = 1'b1;
    sbq.push_back('{1'b1, fn(10'h040)});
    @(posedge clk);
    #2;
    total++;
    if (mem_wren !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre wren=%0b busy=%0b want 1 1", mem_wren, busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if (mem_wren !== 1'b0 || busy !== 1'b0 || d_ack !== 1'b0 || mem_addr !== '0) begin
      bad++;
      $display("FAIL rstmid_async wren=%0b busy=%0b d_ack=%0b addr=%h want 0 0 0 000",
               mem_wren, busy, d_ack, mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (d_ack === 1'b1) begin
        ack_cnt++;
        d_req = 1'b0;
      end
    end
    d_wren = 1'b0;
    total++;
    if (ack_cnt != 1) begin
      bad++;
      $display("FAIL rstmid_acks acks=%0d want 1", ack_cnt);
    end
  endtask

  task test_drop;
    int ack_cnt;
    ack_cnt = 0;
    d_addr = 10'h030; d_wren = 1'b0; d_width = 2'b10;
    d_req = 1'b1;
    sbq.push_back('{1'b1, fn(10'h030)});
    @(posedge clk);
    @(negedge clk);
    d_req = 1'b0;
    if (d_ack === 1'b1) ack_cnt++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_ack === 1'b1) ack_cnt++;
    end
    total++;
    if (ack_cnt != 1 || busy !== 1'b0 || d_rdata !== fn(10'h030)) begin
      bad++;
      $display("FAIL drop_complete acks=%0d busy=%0b rdata=%h want 1 0 %h",
               ack_cnt, busy, d_rdata, fn(10'h030));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = fn(10'(i));
    test_reset();
    test_fetch();
    test_store();
    test_arbitration();
    test_reset_mid();
    test_drop();
    repeat (2) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover pending=%0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
